// File: rtl/reg_file_mp_pkg.sv
// ============================================================================
// Module      : regfile_pkg
// Description : Shared defaults, typedefs and constants for the multi-port
//               register file and its scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package regfile_pkg;
    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;
    localparam int ZERO_REG  = 0;

    typedef logic [4:0]  reg_addr_t;
    typedef logic [31:0] xdata_t;
endpackage

`default_nettype wire

// File: rtl/reg_file_mp_scoreboard.sv
// ============================================================================
// Module      : rf_scoreboard
// Description : Busy-bit scoreboard for RAW hazard detection; issue sets,
//               writeback (and debug write) clears, set wins on conflict.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rf_scoreboard
    import regfile_pkg::*;
#(
    parameter  int NREGS = NREGS_DEF,
    parameter  int NW    = 1,
    parameter  int NR    = 2,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NW-1:0]          we,
    input  logic [NW-1:0][AW-1:0]  waddr,
    input  logic                   dbg_clr,
    input  logic [AW-1:0]          dbg_addr,
    input  logic                   issue_valid,
    input  logic [AW-1:0]          issue_rd,
    input  logic [NR-1:0][AW-1:0]  raddr,
    output logic [NR-1:0]          rbusy,
    output logic [NREGS-1:0]       busy_vec
);

    localparam logic [AW-1:0] c_zero = AW'(ZERO_REG);

    logic [NREGS-1:0] r_busy;
    logic [NREGS-1:0] w_busy_nxt;

    // Clears first, then the set, so a younger producer overrides writeback.
    always_comb begin
        w_busy_nxt = r_busy;
        for (int j = 0; j < NW; j++) begin
            if (we[j]) begin
                w_busy_nxt[waddr[j]] = 1'b0;
            end
        end
        if (dbg_clr) begin
            w_busy_nxt[dbg_addr] = 1'b0;
        end
        if (issue_valid && (issue_rd != c_zero)) begin
            w_busy_nxt[issue_rd] = 1'b1;
        end
        w_busy_nxt[ZERO_REG] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    // A same-cycle writeback makes the operand available now.
    always_comb begin
        for (int i = 0; i < NR; i++) begin
            rbusy[i] = r_busy[raddr[i]];
            for (int j = 0; j < NW; j++) begin
                if (we[j] && (waddr[j] == raddr[i])) begin
                    rbusy[i] = 1'b0;
                end
            end
        end
    end

    assign busy_vec = r_busy;

endmodule

`default_nettype wire

// File: rtl/reg_file_mp.sv
// ============================================================================
// Module      : reg_file_mp
// Description : Parametrised NR-read / NW-write register file with same-cycle
//               write bypass, hardwired x0 and busy-bit scoreboard.
//               Optional debug port enabled by REGFILE_DEBUG_PORT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_file_mp
    import regfile_pkg::*;
#(
    parameter  int XLEN  = XLEN_DEF,
    parameter  int NREGS = NREGS_DEF,
    parameter  int NR    = 2,
    parameter  int NW    = 1,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic                   clk,
    input  logic                   rst,
`ifdef REGFILE_DEBUG_PORT_EN
    input  logic [AW-1:0]          dbg_addr,
    input  logic                   dbg_we,
    input  logic [XLEN-1:0]        dbg_wdata,
    output logic [XLEN-1:0]        dbg_rdata,
`endif
    input  logic [NW-1:0]          we,
    input  logic [NW-1:0][AW-1:0]  waddr,
    input  logic [NW-1:0][XLEN-1:0] wdata,
    input  logic [NR-1:0][AW-1:0]  raddr,
    output logic [NR-1:0][XLEN-1:0] rdata,
    output logic [NR-1:0]          rbusy,
    input  logic                   issue_valid,
    input  logic [AW-1:0]          issue_rd,
    output logic [NREGS-1:0]       busy_vec
);

    localparam logic [AW-1:0] c_zero = AW'(ZERO_REG);

    logic            w_dbg_we;
    logic [AW-1:0]   w_dbg_addr;
    logic [XLEN-1:0] w_dbg_wdata;

`ifdef REGFILE_DEBUG_PORT_EN
    assign w_dbg_we    = dbg_we && (dbg_addr != c_zero);
    assign w_dbg_addr  = dbg_addr;
    assign w_dbg_wdata = dbg_wdata;
`else
    assign w_dbg_we    = 1'b0;
    assign w_dbg_addr  = '0;
    assign w_dbg_wdata = '0;
`endif

    logic [XLEN-1:0] w_regs [NREGS];

    assign w_regs[0] = '0;

    // Debug write first, then ports in ascending order: the last assignment
    // wins, giving highest-index functional port the final say.
    generate
        for (genvar r = 1; r < NREGS; r++) begin : g_reg
            logic [XLEN-1:0] r_q;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_q <= '0;
                end else begin
                    if (w_dbg_we && (w_dbg_addr == AW'(r))) begin
                        r_q <= w_dbg_wdata;
                    end
                    for (int j = 0; j < NW; j++) begin
                        if (we[j] && (waddr[j] == AW'(r))) begin
                            r_q <= wdata[j];
                        end
                    end
                end
            end

            assign w_regs[r] = r_q;
        end
    endgenerate

    always_comb begin
        for (int i = 0; i < NR; i++) begin
            rdata[i] = w_regs[raddr[i]];
            for (int j = 0; j < NW; j++) begin
                if (we[j] && (waddr[j] == raddr[i]) && (raddr[i] != c_zero)) begin
                    rdata[i] = wdata[j];
                end
            end
        end
    end

`ifdef REGFILE_DEBUG_PORT_EN
    assign dbg_rdata = w_regs[dbg_addr];
`endif

    rf_scoreboard #(
        .NREGS (NREGS),
        .NW    (NW),
        .NR    (NR)
    ) u_scoreboard (
        .clk         (clk),
        .rst         (rst),
        .we          (we),
        .waddr       (waddr),
        .dbg_clr     (w_dbg_we),
        .dbg_addr    (w_dbg_addr),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .raddr       (raddr),
        .rbusy       (rbusy),
        .busy_vec    (busy_vec)
    );

endmodule

`default_nettype wire
